// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared state encoding and op codes for the serial add/sub datapath

package serial_arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_sub_bit.sv
// rtl/add_sub_bit.sv - combinational one-bit full adder cell

module add_sub_bit (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial W-bit adder/subtractor, one bit per clock, LSB first

module serial_add_sub
   import serial_arith_pkg::*;
#(
   parameter  int W     = 8,
   localparam int CNT_W = $clog2(W)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         carry_out,
   output logic         overflow
);

   state_t           state;
   state_t           next_state;
   logic [W-1:0]     a_sh;
   logic [W-1:0]     b_sh;
   logic [W-1:0]     r_sh;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             bit_s;
   logic             bit_c;
   logic             load;
   logic             last;

   assign last = (cnt == CNT_W'(W - 1));
   assign busy = (state == ST_BUSY);
   assign done = (state == ST_DONE);

   add_sub_bit u_cell (
      .x    (a_sh[0]),
      .y    (b_sh[0]),
      .cin  (carry),
      .s    (bit_s),
      .cout (bit_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      load       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               next_state = ST_BUSY;
               load       = 1'b1;
            end
         end
         ST_BUSY: begin
            if (last) begin
               next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            // Accepting start here gives back-to-back operations without an idle gap
            if (start) begin
               next_state = ST_BUSY;
               load       = 1'b1;
            end else begin
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh      <= '0;
         b_sh      <= '0;
         r_sh      <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else if (load) begin
         // Subtraction runs as a + ~b + 1: invert b here and seed the carry with 1
         a_sh  <= a;
         b_sh  <= (op == OP_SUB) ? ~b : b;
         carry <= (op == OP_SUB);
         cnt   <= '0;
      end else if (state == ST_BUSY) begin
         a_sh  <= {1'b0, a_sh[W-1:1]};
         b_sh  <= {1'b0, b_sh[W-1:1]};
         r_sh  <= {bit_s, r_sh[W-1:1]};
         carry <= bit_c;
         cnt   <= cnt + 1'b1;
         if (last) begin
            result    <= {bit_s, r_sh[W-1:1]};
            carry_out <= bit_c;
            overflow  <= carry ^ bit_c;
         end
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - directed self-checking bench for serial_add_sub

module tb_serial_add_sub;
   import serial_arith_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       op;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       carry_out;
   logic       overflow;

   int checks = 0;
   int errors = 0;
   int cyc;
   int busy_cyc;
   int extra_done;
   logic moved;

   serial_add_sub #(.W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Called just after an edge; start is sampled at the next edge, then inputs are scrambled
   task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic opv);
      a = av; b = bv; op = opv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = ~av; b = ~bv; op = ~opv;
   endtask

   // Counts edges until done; optionally pulses a rogue start at busy sample inj_at
   task automatic wait_done(input int inj_at, output int n, output int nb, output logic mv);
      logic [7:0] prev;
      prev = result;
      n = 0; nb = 0; mv = 1'b0;
      while (!done && n < 40) begin
         if (busy) nb++;
         if (result !== prev) mv = 1'b1;
         if (n == inj_at) begin
            start = 1'b1; a = 8'hAA; b = 8'h55; op = OP_SUB;
         end
         @(posedge clk); #1;
         n++;
         if (n == inj_at + 1) start = 1'b0;
      end
   endtask

   task automatic run_check(input string tag, input logic [7:0] er, input logic ec, input logic ev);
      wait_done(-1, cyc, busy_cyc, moved);
      chk({tag, "_latency"}, cyc, 8);
      chk({tag, "_busy_cycles"}, busy_cyc, 8);
      chk({tag, "_held"}, moved, 0);
      chk({tag, "_result"}, result, er);
      chk({tag, "_carry"}, carry_out, ec);
      chk({tag, "_ovf"}, overflow, ev);
      @(posedge clk); #1;
      chk({tag, "_done_drop"}, {busy, done}, 2'b00);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {busy, done, result, carry_out, overflow}, 12'h000);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_reset", {busy, done}, 2'b00);

      // 1: plain add
      start_op(8'h25, 8'h13, OP_ADD);
      run_check("add_25_13", 8'h38, 1'b0, 1'b0);

      // 2: signed overflow and unsigned carry
      start_op(8'h7F, 8'h01, OP_ADD);
      run_check("add_7f_01", 8'h80, 1'b0, 1'b1);
      start_op(8'hFF, 8'h01, OP_ADD);
      run_check("add_ff_01", 8'h00, 1'b1, 1'b0);
      start_op(8'h80, 8'h80, OP_ADD);
      run_check("add_80_80", 8'h00, 1'b1, 1'b1);

      // 3: subtraction, borrow and signed overflow
      start_op(8'h10, 8'h20, OP_SUB);
      run_check("sub_10_20", 8'hF0, 1'b0, 1'b0);
      start_op(8'h80, 8'h01, OP_SUB);
      run_check("sub_80_01", 8'h7F, 1'b1, 1'b1);

      // 4: start while busy is ignored
      start_op(8'h11, 8'h22, OP_ADD);
      wait_done(3, cyc, busy_cyc, moved);
      chk("busy_start_latency", cyc, 8);
      chk("busy_start_held", moved, 0);
      chk("busy_start_result", result, 8'h33);
      chk("busy_start_flags", {carry_out, overflow}, 2'b00);
      extra_done = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 12; i++) begin
         if (done) extra_done++;
         @(posedge clk); #1;
      end
      chk("busy_start_one_done", extra_done, 0);
      chk("busy_start_result_kept", result, 8'h33);

      // 5: back-to-back with start in the DONE cycle
      start_op(8'h40, 8'h05, OP_ADD);
      wait_done(-1, cyc, busy_cyc, moved);
      chk("b2b_first_result", result, 8'h45);
      chk("b2b_first_done", done, 1'b1);
      start_op(8'h01, 8'h01, OP_ADD);
      chk("b2b_rebusy", {busy, done}, 2'b10);
      chk("b2b_first_held", result, 8'h45);
      run_check("b2b_second", 8'h02, 1'b0, 1'b0);

      // 6: reset mid-operation
      start_op(8'h33, 8'h44, OP_SUB);
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("abort_async_outputs", {busy, done, result, carry_out, overflow}, 12'h000);
      @(posedge clk); #1;
      rst_n = 1'b1;
      extra_done = 0;
      for (int i = 0; i < 10; i++) begin
         if (done || busy) extra_done++;
         @(posedge clk); #1;
      end
      chk("abort_no_done", extra_done, 0);
      start_op(8'h0F, 8'h01, OP_SUB);
      run_check("after_abort", 8'h0E, 1'b1, 1'b0);
      start_op(8'h00, 8'h01, OP_SUB);
      run_check("sub_00_01", 8'hFF, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
